bin2bcd_seq_ctrl: RTL and testbench
===================================

BIN2BCD_SEQ_CTRL -- requirements
Module: bin2bcd_seq_ctrl

Interface
REQ-001 Parameter AUTO, default 1: 1 starts a conversion automatically when SW differs from the last converted value; 0 starts on START only.
REQ-002 Parameter BLANK, default 0: 1 blanks leading-zero digits on HEX2/HEX1; HEX0 is never blanked.
REQ-003 Port CLOCK_50, input, 1: single clock, rising edge.
REQ-004 Port RESET, input, 1: asynchronous, active-high reset.
REQ-005 Port SW, input, 8: unsigned binary operand, 0..255.
REQ-006 Port START, input, 1: conversion request, level-sampled.
REQ-007 Port BUSY, output, 1: high while a conversion is in progress.
REQ-008 Port DONE, output, 1: one-cycle pulse when a new result is registered.
REQ-009 Port BCD, output, 12: registered result; [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-010 Ports HEX0_D, HEX1_D, HEX2_D, output, 7 each: active-low segments {g,f,e,d,c,b,a} for ones, tens and hundreds.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE, a trigger SHALL capture SW into a 20-bit working register {12'b0, SW}, clear the 3-bit iteration counter and enter SHIFT next cycle.
- Trigger = START, or (AUTO=1 and SW != last converted value).
REQ-013 Each SHIFT cycle SHALL perform one double-dabble step:
- add 3 to every BCD nibble of the working register that is >= 5;
- then shift the whole register left by 1.
REQ-014 SHIFT SHALL last exactly 8 cycles; after the 8th step the FSM SHALL enter DONE.
REQ-015 In DONE, the FSM SHALL load BCD from working[19:8], store the captured operand as the last converted value, assert DONE for that one cycle and return to IDLE.
REQ-016 Latency: trigger sampled in cycle N -> DONE=1 and new BCD/HEX visible in cycle N+9.
REQ-017 Throughput: a trigger present in the IDLE cycle right after DONE SHALL start the next conversion, so the minimum period is 10 cycles.
REQ-018 BUSY SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 START and SW changes while BUSY=1 SHALL be ignored; the captured operand SHALL stay stable.
REQ-020 AUTO=1: SW that is unchanged after a completed conversion SHALL NOT retrigger.
REQ-021 BCD nibbles SHALL always be 0..9; BCD SHALL never exceed 12'h255.
REQ-022 Segment encoding SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- blank=1111111.
REQ-023 BLANK=1: HEX2 SHALL be blank when hundreds=0; HEX1 SHALL be blank when hundreds=0 and tens=0.
REQ-024 HEX outputs SHALL be combinational decodes of the registered BCD only, with no dependence on the working register.

Reset
REQ-025 RESET=1 SHALL force, asynchronously:
- state IDLE; working register, counter, BCD and last converted value to 0;
- BUSY=0, DONE=0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion, and no DONE SHALL follow.
REQ-027 After reset release with AUTO=1 and SW != 0, a conversion SHALL start on the first clock edge.

Structure
REQ-028 The state encoding, the segment constants and SEG_BLANK SHALL live in a shared package bcd_pkg.
REQ-029 The segment decoder SHALL be one sub-module, seg7_dec (4-bit digit + blank in, 7-bit segments out), instantiated three times.

Verification
REQ-030 AUTO=0, SW=8'd255, START pulse in cycle N -> DONE in cycle N+9, BCD=12'h255, HEX2/1/0=0100100/0010010/0010010.
REQ-031 SW=8'd0, START -> BCD=12'h000; BLANK=0: all HEX=1000000; BLANK=1: HEX2/HEX1=1111111, HEX0=1000000.
REQ-032 AUTO=1, SW 8'd9 -> 8'd10 -> BCD 12'h009 then 12'h010, with exactly two DONE pulses and none while SW is held.
REQ-033 START held high, SW changed to 8'd99 in SHIFT cycle 3 -> result matches the operand captured at the trigger; 99 converts on the following conversion.
REQ-034 RESET pulsed in SHIFT cycle 5 -> BUSY=0 immediately, BCD=0, no DONE pulse.
REQ-035 Exhaustive sweep of SW 0..255 with AUTO=0 -> BCD equals the decimal value for every input.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, iteration constants and seven-segment patterns.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int OP_W   = 8;   // binary operand width
    localparam int BCD_W  = 12;  // three BCD digits
    localparam int WORK_W = 20;  // {bcd, binary} double-dabble register

    // Counter value of the final double-dabble step (8 steps: 0..7).
    localparam logic [2:0] LAST_STEP = 3'd7;

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_dec.sv
// Seven-segment decoder for one BCD digit, with a blanking control.
// Non-decimal codes show blank so a corrupted digit never lights a glyph.
module seg7_dec
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Pure lookup from digit to active-low segment pattern.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one step
// per clock) with registered result and seven-segment display outputs.
module bin2bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter bit AUTO  = 1'b1,
    parameter bit BLANK = 1'b0
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [OP_W-1:0]  SW,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [BCD_W-1:0] BCD,
    output logic [6:0]       HEX0_D,
    output logic [6:0]       HEX1_D,
    output logic [6:0]       HEX2_D
);

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [OP_W-1:0]     last_q, last_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;

    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_step;
    logic                trigger;

    // One double-dabble step: correct each BCD nibble >= 5 by +3, then shift.
    // The binary part below bit 8 passes through unchanged before the shift.
    assign work_adj[7:0] = work_q[7:0];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_nib
            assign work_adj[8 + 4*gi +: 4] = (work_q[8 + 4*gi +: 4] >= 4'd5)
                                           ? work_q[8 + 4*gi +: 4] + 4'd3
                                           : work_q[8 + 4*gi +: 4];
        end
    endgenerate
    assign work_step = work_adj << 1;

    assign trigger = START || (AUTO && (SW != last_q));

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            last_q  <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
        end
    end

    // Next-state and datapath control.
    // The result and last operand are written on the edge that enters DONE,
    // so the new BCD is already visible during the DONE pulse cycle.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    work_d  = {{(WORK_W-OP_W){1'b0}}, SW};
                    op_d    = SW;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == LAST_STEP) begin
                    bcd_d   = work_step[WORK_W-1:OP_W];
                    last_d  = op_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);
    assign BCD  = bcd_q;

    // Display decode reads only the registered result.
    logic blank2, blank1;
    assign blank2 = BLANK && (bcd_q[11:8] == 4'd0);
    assign blank1 = BLANK && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);

    seg7_dec u_hex0 (.digit_i(bcd_q[3:0]),  .blank_i(1'b0),   .seg_o(HEX0_D));
    seg7_dec u_hex1 (.digit_i(bcd_q[7:4]),  .blank_i(blank1), .seg_o(HEX1_D));
    seg7_dec u_hex2 (.digit_i(bcd_q[11:8]), .blank_i(blank2), .seg_o(HEX2_D));

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Directed bench for bin2bcd_seq_ctrl: one instance with START-only triggering
// and no blanking, one with automatic triggering and leading-zero blanking.
module tb_bin2bcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_sw = 8'd0, b_sw = 8'd0;
    logic       a_start = 1'b0, b_start = 1'b0;

    logic        a_busy, a_done, b_busy, b_done;
    logic [11:0] a_bcd, b_bcd;
    logic [6:0]  a_hex0, a_hex1, a_hex2, b_hex0, b_hex1, b_hex2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_ctrl #(.AUTO(1'b0), .BLANK(1'b0)) dut_a (
        .CLOCK_50(clk), .RESET(rst), .SW(a_sw), .START(a_start),
        .BUSY(a_busy), .DONE(a_done), .BCD(a_bcd),
        .HEX0_D(a_hex0), .HEX1_D(a_hex1), .HEX2_D(a_hex2)
    );

    bin2bcd_seq_ctrl #(.AUTO(1'b1), .BLANK(1'b1)) dut_b (
        .CLOCK_50(clk), .RESET(rst), .SW(b_sw), .START(b_start),
        .BUSY(b_busy), .DONE(b_done), .BCD(b_bcd),
        .HEX0_D(b_hex0), .HEX1_D(b_hex1), .HEX2_D(b_hex2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // START pulse on instance A from an idle cycle; returns cycles to DONE.
    task automatic conv_a(input logic [7:0] v, output int lat);
        @(negedge clk);
        a_sw    = v;
        a_start = 1'b1;
        @(negedge clk);
        lat     = 1;
        a_start = 1'b0;
        check("a_busy_shift", a_busy, 1);
        while (!a_done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("a_done_seen", a_done, 1);
        $display("conv A sw=%0d bcd=%03h lat=%0d", v, a_bcd, lat);
    endtask

    task automatic wait_b_done();
        int n = 0;
        while (!b_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", b_done, 1);
        $display("conv B sw=%0d bcd=%03h", b_sw, b_bcd);
    endtask

    task automatic count_b(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (b_done) pulses++;
        end
        $display("window B sw=%0d pulses=%0d bcd=%03h", b_sw, pulses, b_bcd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p, pa, pb;
        logic [11:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_bcd",  a_bcd,  0);
        check("rst_b_bcd",  b_bcd,  0);
        check("rst_a_hex0", a_hex0, 7'b1000000);
        check("rst_b_hex2", b_hex2, 7'b1111111);
        rst = 1'b0;
        @(negedge clk);
        check("idle_b_busy", b_busy, 0);

        // 255 with latency
        conv_a(8'd255, lat);
        check("lat_255",  lat,    9);
        check("bcd_255",  a_bcd,  12'h255);
        check("hex2_255", a_hex2, 7'b0100100);
        check("hex1_255", a_hex1, 7'b0010010);
        check("hex0_255", a_hex0, 7'b0010010);
        @(negedge clk);
        check("after_done_pulse", a_done, 0);
        check("after_done_busy",  a_busy, 0);

        // zero, unblanked and blanked
        conv_a(8'd0, lat);
        check("bcd_0",   a_bcd,  12'h000);
        check("hex2_0",  a_hex2, 7'b1000000);
        check("hex1_0",  a_hex1, 7'b1000000);
        check("hex0_0",  a_hex0, 7'b1000000);
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_b_done();
        check("b_bcd_0",  b_bcd,  12'h000);
        check("b_hex2_0", b_hex2, 7'b1111111);
        check("b_hex1_0", b_hex1, 7'b1111111);
        check("b_hex0_0", b_hex0, 7'b1000000);

        // automatic triggering on SW change
        @(negedge clk);
        b_sw = 8'd9;
        count_b(25, p);
        check("auto9_pulses", p, 1);
        check("auto9_bcd",    b_bcd,  12'h009);
        check("auto9_hex1",   b_hex1, 7'b1111111);
        check("auto9_hex0",   b_hex0, 7'b0010000);
        b_sw = 8'd10;
        count_b(25, p);
        check("auto10_pulses", p, 1);
        check("auto10_bcd",    b_bcd,  12'h010);
        check("auto10_hex2",   b_hex2, 7'b1111111);
        check("auto10_hex1",   b_hex1, 7'b1111001);
        check("auto10_hex0",   b_hex0, 7'b1000000);
        count_b(30, p);
        check("hold_pulses", p, 0);

        // SW change during SHIFT is ignored, START held gives back-to-back runs
        @(negedge clk);
        a_sw    = 8'd37;
        a_start = 1'b1;
        repeat (3) @(negedge clk);
        a_sw = 8'd99;
        check("busy_shift3", a_busy, 1);
        lat = 3;
        while (!a_done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("held_lat", lat, 9);
        check("held_bcd_37", a_bcd, 12'h037);
        lat = 0;
        @(negedge clk);
        lat++;
        while (!a_done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        a_start = 1'b0;
        check("period", lat, 10);
        check("held_bcd_99", a_bcd, 12'h099);
        repeat (2) @(negedge clk);
        check("no_third_conv", a_busy, 0);

        // blanking with hundreds non-zero and tens zero
        b_sw = 8'd105;
        count_b(25, p);
        check("b105_pulses", p, 1);
        check("b105_bcd",  b_bcd,  12'h105);
        check("b105_hex2", b_hex2, 7'b1111001);
        check("b105_hex1", b_hex1, 7'b1000000);
        check("b105_hex0", b_hex0, 7'b0010010);

        // reset in SHIFT cycle 5 aborts; B auto-starts right after release
        @(negedge clk);
        a_sw    = 8'd200;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_bcd",  a_bcd,  0);
        check("abort_b_bcd", b_bcd, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("b_autostart_busy", b_busy, 1);
        pa = 0;
        pb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_done) pa++;
            if (b_done) pb++;
        end
        check("abort_no_done", pa, 0);
        check("abort_bcd_hold", a_bcd, 0);
        check("b_post_rst_pulses", pb, 1);
        check("b_post_rst_bcd", b_bcd, 12'h105);

        // exhaustive sweep
        for (int v = 0; v < 256; v++) begin
            conv_a(8'(v), lat);
            e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            check($sformatf("sweep_%0d", v), a_bcd, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
